fifo_pair_packer: RTL and testbench

//  Upstream feeder for the dual-write FIFO. Collects single result words, one per cycle.

---
 rtl/fifo_pair_packer_pkg.sv | 11 +
 rtl/fifo_pair_packer_if.sv | 28 ++
 rtl/fifo_pair_packer_timeout_ctr.sv | 26 ++
 rtl/fifo_pair_packer.sv | 111 +++++++++++
 tb/tb_fifo_pair_packer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pair_packer_pkg.sv
// Shared types and default constants for the pair packer.
package fifo_pair_packer_pkg;

    typedef enum logic {IDLE, HALF} state_e;

    localparam int                        DEF_DATA_WIDTH     = 65;
    localparam logic [DEF_DATA_WIDTH-1:0] DEF_PAD_WORD       = '1;
    localparam int                        DEF_CNT_WIDTH      = 16;
    localparam int                        DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/fifo_pair_packer_if.sv
// Producer/FIFO-facing bus of the pair packer; master drives words and back-pressure.
interface fifo_pair_packer_if
    import fifo_pair_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
    logic [DATA_WIDTH-1:0] In_data;
    logic                  In_valid;
    logic                  In_ready;
    logic                  Flush_in;
    logic                  Full_in;
    logic [DATA_WIDTH-1:0] Data_out_1;
    logic [DATA_WIDTH-1:0] Data_out_2;
    logic                  WriteEn_out_2;
    logic [CNT_WIDTH-1:0]  Pair_count_out;
    logic [CNT_WIDTH-1:0]  Pad_count_out;

    modport master (
        output In_data, In_valid, Flush_in, Full_in,
        input  In_ready, Data_out_1, Data_out_2, WriteEn_out_2, Pair_count_out, Pad_count_out
    );

    modport slave (
        input  In_data, In_valid, Flush_in, Full_in,
        output In_ready, Data_out_1, Data_out_2, WriteEn_out_2, Pair_count_out, Pad_count_out
    );
endinterface

// File: rtl/fifo_pair_packer_timeout_ctr.sv
// Idle-cycle counter for a held odd word; pulses expire on the TIMEOUT_CYCLES-th idle cycle.
module pair_timeout_ctr
    import fifo_pair_packer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam int            CW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Saturates so a long back-pressured wait cannot wrap and re-fire.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                cnt_q <= '0;
        else if (clr)              cnt_q <= '0;
        else if (en && cnt_q != '1) cnt_q <= cnt_q + CW'(1);
    end

    assign expire = en & (cnt_q == LAST);
endmodule

// File: rtl/fifo_pair_packer.sv
// Packs single words into registered pairs for the dual-write FIFO.
// Optional auto-flush of a held odd word: define FIFO_PAIR_PACKER_TIMEOUT_EN.
module fifo_pair_packer
    import fifo_pair_packer_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD   = DATA_WIDTH'(DEF_PAD_WORD),
    parameter int                    CNT_WIDTH  = DEF_CNT_WIDTH
`ifdef FIFO_PAIR_PACKER_TIMEOUT_EN
    ,
    parameter int                    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic              Clk,
    input  logic              Rst_n,
    fifo_pair_packer_if.slave bus
);
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, d1_q, d2_q, src1;
    logic [CNT_WIDTH-1:0]  pair_cnt_q, pad_cnt_q;
    logic                  we_q, pend_q, pend_d;
    logic                  accept, flush_req, tmo_expire;
    logic                  ld_hold, issue, pad;

    assign bus.In_ready = ~bus.Full_in;
    assign accept       = bus.In_valid & ~bus.Full_in;
    assign flush_req    = bus.Flush_in | tmo_expire;

`ifdef FIFO_PAIR_PACKER_TIMEOUT_EN
    pair_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .en     ((state_q == HALF) & ~accept),
        .clr    ((state_q != HALF) | accept),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ld_hold = 1'b0;
        issue   = 1'b0;
        pad     = 1'b0;
        src1    = bus.In_data;
        case (state_q)
            IDLE: begin
                if (accept && flush_req) begin
                    issue = 1'b1;
                    pad   = 1'b1;
                end else if (accept) begin
                    ld_hold = 1'b1;
                    state_d = HALF;
                end
            end
            HALF: begin
                // A completing word always wins over a flush; the pair satisfies it.
                if (accept) begin
                    issue   = 1'b1;
                    src1    = hold_q;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else if ((flush_req || pend_q) && !bus.Full_in) begin
                    issue   = 1'b1;
                    pad     = 1'b1;
                    src1    = hold_q;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else if (flush_req) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold_q     <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            we_q       <= 1'b0;
            pend_q     <= 1'b0;
            pair_cnt_q <= '0;
            pad_cnt_q  <= '0;
        end else begin
            we_q   <= issue;
            pend_q <= pend_d;
            if (ld_hold) hold_q <= bus.In_data;
            if (issue) begin
                d1_q       <= src1;
                d2_q       <= pad ? PAD_WORD : bus.In_data;
                pair_cnt_q <= pair_cnt_q + CNT_WIDTH'(1);
                if (pad) pad_cnt_q <= pad_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.Data_out_1     = d1_q;
    assign bus.Data_out_2     = d2_q;
    assign bus.WriteEn_out_2  = we_q;
    assign bus.Pair_count_out = pair_cnt_q;
    assign bus.Pad_count_out  = pad_cnt_q;
endmodule

// File: tb/tb_fifo_pair_packer.sv
// Self-checking bench: queue-based model checked every cycle, plus directed literal checks.
module tb_fifo_pair_packer;
    localparam int DW = 65;
    localparam int CW = 16;
`ifdef FIFO_PAIR_PACKER_TIMEOUT_EN
    localparam int TMO = 8;
`endif
    localparam logic [DW-1:0] PAD = '1;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   run_cmp = 1'b0;

    fifo_pair_packer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

    fifo_pair_packer #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
`ifdef FIFO_PAIR_PACKER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: at most one held word in a queue, a pending-flush flag, and the last pair issued.
    logic [DW-1:0] held[$];
    bit            pend;
    int            idle_run;
    bit            m_we;
    logic [DW-1:0] m_d1, m_d2;
    int unsigned   m_pairs, m_pads;

    task automatic m_issue(logic [DW-1:0] a, logic [DW-1:0] b, bit padded);
        m_we = 1'b1;
        m_d1 = a;
        m_d2 = b;
        m_pairs++;
        if (padded) m_pads++;
    endtask

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            held.delete();
            pend = 0; idle_run = 0; m_we = 0;
            m_d1 = '0; m_d2 = '0; m_pairs = 0; m_pads = 0;
        end else begin : model_step
            bit acc, fl, was_half;
            acc      = bus.In_valid && !bus.Full_in;
            fl       = bus.Flush_in;
            was_half = (held.size() == 1);
`ifdef FIFO_PAIR_PACKER_TIMEOUT_EN
            if (was_half && !acc && idle_run + 1 >= TMO) fl = 1;
`endif
            m_we = 0;
            if (!was_half) begin
                if (acc && fl) m_issue(bus.In_data, PAD, 1);
                else if (acc)  held.push_back(bus.In_data);
            end else if (acc) begin
                m_issue(held.pop_front(), bus.In_data, 0);
                pend = 0;
            end else if ((fl || pend) && !bus.Full_in) begin
                m_issue(held.pop_front(), PAD, 1);
                pend = 0;
            end else if (fl) begin
                pend = 1;
            end
            idle_run = (was_half && held.size() == 1 && !acc) ? idle_run + 1 : 0;
        end
    end

    always @(negedge Clk) begin
        if (Rst_n && run_cmp) begin
            chk("cyc_we",    DW'(bus.WriteEn_out_2), DW'(m_we));
            chk("cyc_d1",    bus.Data_out_1, m_d1);
            chk("cyc_d2",    bus.Data_out_2, m_d2);
            chk("cyc_pairs", DW'(bus.Pair_count_out), DW'(CW'(m_pairs)));
            chk("cyc_pads",  DW'(bus.Pad_count_out),  DW'(CW'(m_pads)));
            chk("cyc_ready", DW'(bus.In_ready), DW'(!bus.Full_in));
        end
    end

    task automatic tick(bit v, logic [DW-1:0] d, bit f, bit full);
        bus.In_valid = v;
        bus.In_data  = d;
        bus.Flush_in = f;
        bus.Full_in  = full;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        tick(0, '0, 0, 0);
    endtask

    initial begin
        logic [DW-1:0] A, B, C, D;
        logic [95:0]   rnd;
        A = 65'h1_0000_0000_0000_00AA;
        B = 65'h0_1234_5678_9ABC_DEF0;
        C = 65'h1_FEDC_BA98_7654_3210;
        D = 65'h0_0000_0000_0000_0DDD;
        bus.In_valid = 0; bus.In_data = '0; bus.Flush_in = 0; bus.Full_in = 0;

        Rst_n = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_we",    DW'(bus.WriteEn_out_2), '0);
        chk("rst_d1",    bus.Data_out_1, '0);
        chk("rst_d2",    bus.Data_out_2, '0);
        chk("rst_pairs", DW'(bus.Pair_count_out), '0);
        chk("rst_pads",  DW'(bus.Pad_count_out), '0);
        chk("rst_ready", DW'(bus.In_ready), DW'(1));
        Rst_n   = 1;
        run_cmp = 1;

        // Four back-to-back words make two pairs.
        tick(1, A, 0, 0); chk("t1_nowe", DW'(bus.WriteEn_out_2), '0);
        tick(1, B, 0, 0); chk("t1_we1", DW'(bus.WriteEn_out_2), DW'(1));
        chk("t1_d1a", bus.Data_out_1, A); chk("t1_d2a", bus.Data_out_2, B);
        tick(1, C, 0, 0); chk("t1_gap", DW'(bus.WriteEn_out_2), '0);
        chk("t1_hold", bus.Data_out_1, A);
        tick(1, D, 0, 0); chk("t1_we2", DW'(bus.WriteEn_out_2), DW'(1));
        chk("t1_d1c", bus.Data_out_1, C); chk("t1_d2d", bus.Data_out_2, D);
        chk("t1_pairs", DW'(bus.Pair_count_out), DW'(2));
        idle();

        // Odd word flushed three cycles later.
        tick(1, A, 0, 0); idle(); idle();
        tick(0, '0, 1, 0); chk("t2_we", DW'(bus.WriteEn_out_2), DW'(1));
        chk("t2_d1", bus.Data_out_1, A); chk("t2_d2", bus.Data_out_2, PAD);
        chk("t2_pads", DW'(bus.Pad_count_out), DW'(1));
        idle(); chk("t2_once", DW'(bus.WriteEn_out_2), '0);

        // Flush under back-pressure is deferred until Full_in drops.
        tick(1, C, 0, 0);
        tick(0, '0, 0, 1); chk("t3_ready", DW'(bus.In_ready), '0);
        tick(0, '0, 1, 1); chk("t3_blk0", DW'(bus.WriteEn_out_2), '0);
        for (int i = 0; i < 3; i++) begin
            tick(1, D, 0, 1); chk("t3_blk", DW'(bus.WriteEn_out_2), '0);
        end
        tick(0, '0, 0, 0); chk("t3_we", DW'(bus.WriteEn_out_2), DW'(1));
        chk("t3_d1", bus.Data_out_1, C); chk("t3_d2", bus.Data_out_2, PAD);
        chk("t3_pads", DW'(bus.Pad_count_out), DW'(2));
        chk("t3_pairs", DW'(bus.Pair_count_out), DW'(4));
        idle();

        // Flush coinciding with the completing word adds no pad.
        tick(1, A, 0, 0);
        tick(1, B, 1, 0); chk("t4_d1", bus.Data_out_1, A); chk("t4_d2", bus.Data_out_2, B);
        idle(); chk("t4_nopad", DW'(bus.WriteEn_out_2), '0);
        chk("t4_pads", DW'(bus.Pad_count_out), DW'(2));
        chk("t4_pairs", DW'(bus.Pair_count_out), DW'(5));

        // Reset while a word is held discards it.
        tick(1, D, 0, 0);
        Rst_n = 0; #1;
        chk("t5_rst_pairs", DW'(bus.Pair_count_out), '0);
        chk("t5_rst_d1", bus.Data_out_1, '0);
        @(posedge Clk); #1;
        Rst_n = 1;
        tick(1, B, 1, 0); chk("t5_d1", bus.Data_out_1, B); chk("t5_d2", bus.Data_out_2, PAD);
        chk("t5_pairs", DW'(bus.Pair_count_out), DW'(1));
        chk("t5_pads", DW'(bus.Pad_count_out), DW'(1));
        idle();

        // Held word with no traffic.
        tick(1, C, 0, 0);
        for (int i = 1; i <= 100; i++) begin
            idle();
`ifdef FIFO_PAIR_PACKER_TIMEOUT_EN
            chk("t6_tmo", DW'(bus.WriteEn_out_2), DW'(i == TMO));
`else
            chk("t6_wait", DW'(bus.WriteEn_out_2), '0);
`endif
        end
`ifndef FIFO_PAIR_PACKER_TIMEOUT_EN
        tick(0, '0, 1, 0); chk("t6_flush", bus.Data_out_1, C);
`endif
        idle();

        // Random traffic: busy phase, then sparse phase so odd words linger.
        for (int n = 0; n < 2000; n++) begin
            bit v, f, full;
            rnd  = {$urandom, $urandom, $urandom};
            v    = $urandom_range(0, 99) < ((n < 1400) ? 50 : 8);
            f    = $urandom_range(0, 99) < 6;
            full = $urandom_range(0, 99) < 25;
            tick(v, rnd[DW-1:0], f, full);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
